ahb_slave_mem: RTL and testbench

//  AHB-Lite slave responder. Terminates one ahb_s*_if port of the NoC: decodes address/data phases,

---
 rtl/ahb_slave_mem.sv | 142 ++++++++++++++
 tb/tb_ahb_slave_mem.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave responder backed by a word memory.
// Legal transfers get WAIT_STATES low-ready cycles and then an OKAY completion.
// Illegal transfers get a two-cycle ERROR response.
//
// Handshake: an address phase is taken on a rising edge where hsel, hready and
// htrans[1] are all high. Its data phase ends on the first later edge where
// hreadyout is high, and write data is sampled on that edge.
// The FSM state is kept in the enum-typed signal `state` so that checkers can bind to it.
module ahb_slave_mem #(
   parameter int DEPTH       = 1024,
   parameter int ADDR_W      = 32,
   parameter int WAIT_STATES = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hsel,
   input  logic [ADDR_W-1:0] haddr,
   input  logic [1:0]        htrans,
   input  logic              hwrite,
   input  logic [2:0]        hsize,
   input  logic [2:0]        hburst,
   input  logic [31:0]       hwdata,
   input  logic              hready,
   output logic              hreadyout,
   output logic              hresp,
   output logic [31:0]       hrdata
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(64'(DEPTH) * 64'd4);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

   state_t           state;
   logic             dp_act;   // a legal transfer is in its data phase
   logic             write_q;
   logic [IDX_W-1:0] idx_q;
   logic [3:0]       lanes_q;
   logic [3:0]       cnt;
   logic [31:0]      mem [DEPTH];

   logic             accept;
   logic             illegal;
   logic             misalign;
   logic [3:0]       lanes_n;
   logic             unused_bits;

   // Bursts are handled beat by beat, so hburst and htrans[0] carry no information here.
   assign unused_bits = ^{hburst, htrans[0]};

   assign accept  = hsel & hready & htrans[1];
   assign illegal = ({1'b0, haddr} >= LIMIT) | (hsize > 3'd2) | misalign;

   // Alignment check and little-endian byte-lane enables for the presented transfer
   always_comb begin
      misalign = 1'b0;
      lanes_n  = 4'b1111;
      case (hsize)
         3'd0: lanes_n = 4'b0001 << haddr[1:0];
         3'd1: begin
            misalign = haddr[0];
            lanes_n  = haddr[1] ? 4'b1100 : 4'b0011;
         end
         3'd2: misalign = |haddr[1:0];
         default: ;
      endcase
   end

   // Response FSM: wait-state counting, two-cycle error, address-phase capture
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         hreadyout <= 1'b1;
         hresp     <= 1'b0;
         dp_act    <= 1'b0;
         write_q   <= 1'b0;
         idx_q     <= '0;
         lanes_q   <= '0;
         cnt       <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_ERR2: begin
               // ERR2 is the second error cycle; it can take a new transfer like IDLE does.
               state     <= ST_IDLE;
               hreadyout <= 1'b1;
               hresp     <= 1'b0;
               dp_act    <= 1'b0;
               if (accept) begin
                  if (illegal) begin
                     state     <= ST_ERR1;
                     hreadyout <= 1'b0;
                     hresp     <= 1'b1;
                  end else begin
                     dp_act  <= 1'b1;
                     write_q <= hwrite;
                     idx_q   <= haddr[IDX_W+1:2];
                     lanes_q <= lanes_n;
                     if (WAIT_STATES > 0) begin
                        state     <= ST_WAIT;
                        hreadyout <= 1'b0;
                        cnt       <= 4'(WAIT_STATES - 1);
                     end
                  end
               end
            end
            ST_WAIT: begin
               // The completing cycle runs in IDLE with dp_act still set.
               if (cnt == 4'd0) begin
                  state     <= ST_IDLE;
                  hreadyout <= 1'b1;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            ST_ERR1: begin
               state     <= ST_ERR2;
               hreadyout <= 1'b1;
               hresp     <= 1'b1;
            end
            default: begin
               state     <= ST_IDLE;
               hreadyout <= 1'b1;
               hresp     <= 1'b0;
               dp_act    <= 1'b0;
            end
         endcase
      end
   end

   // Commit enabled byte lanes on the completing edge of a legal write
   always_ff @(posedge clk) begin
      if (!rst && dp_act && hreadyout && write_q) begin
         for (int b = 0; b < 4; b++) begin
            if (lanes_q[b]) mem[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
         end
      end
   end

   // Read data is the whole addressed word for the entire read data phase
   assign hrdata = (dp_act && !write_q) ? mem[idx_q] : 32'h0;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: three instances with 0, 2 and 3 wait states.
// A byte-array memory model with latency rules produces the expected response for every cycle.
module tb_ahb_slave_mem;

   localparam int DEPTH = 1024;
   localparam int NI    = 3;

   function automatic int ws_of(input int i);
      return (i == 0) ? 0 : (i == 1) ? 2 : 3;
   endfunction

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        hsel      [NI];
   logic [31:0] haddr     [NI];
   logic [1:0]  htrans    [NI];
   logic        hwrite    [NI];
   logic [2:0]  hsize     [NI];
   logic [2:0]  hburst    [NI];
   logic [31:0] hwdata    [NI];
   logic        hreadyout [NI];
   logic        hresp     [NI];
   logic [31:0] hrdata    [NI];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      ahb_slave_mem #(.DEPTH(DEPTH), .ADDR_W(32), .WAIT_STATES(ws_of(g))) u_dut (
         .clk       (clk),
         .rst       (rst),
         .hsel      (hsel[g]),
         .haddr     (haddr[g]),
         .htrans    (htrans[g]),
         .hwrite    (hwrite[g]),
         .hsize     (hsize[g]),
         .hburst    (hburst[g]),
         .hwdata    (hwdata[g]),
         .hready    (hreadyout[g]),
         .hreadyout (hreadyout[g]),
         .hresp     (hresp[g]),
         .hrdata    (hrdata[g])
      );
   end

   // ---------------- records ----------------
   typedef struct {
      logic        sel;
      logic [1:0]  trans;
      logic        wr;
      logic [2:0]  size;
      logic [2:0]  burst;
      logic [31:0] addr;
      logic [31:0] wdata;
      bit          chk;
      logic        resp_x;
      logic [31:0] rdata_x;
   } beat_t;

   typedef struct {
      int    dut;
      beat_t b;
   } vec_t;

   beat_t       beat_q [$];
   vec_t        vec    [$];
   logic [33:0] exp_q  [$];   // {hreadyout, hresp, hrdata} per data-phase cycle
   logic [7:0]  mm [NI][DEPTH*4];

   int n_checks = 0;
   int n_pass   = 0;

   // ---------------- scoreboard helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else n_pass++;
   endtask

   function automatic beat_t mk(input logic sel, input logic [1:0] tr, input logic wr,
                                input logic [2:0] sz, input logic [31:0] a,
                                input logic [31:0] wd, input logic [2:0] bu);
      beat_t b;
      b.sel = sel; b.trans = tr; b.wr = wr; b.size = sz; b.addr = a;
      b.wdata = wd; b.burst = bu; b.chk = 1'b0; b.resp_x = 1'b0; b.rdata_x = 32'h0;
      return b;
   endfunction

   function automatic beat_t mkc(input logic sel, input logic [1:0] tr, input logic wr,
                                 input logic [2:0] sz, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [2:0] bu,
                                 input logic rx, input logic [31:0] dx);
      beat_t b;
      b = mk(sel, tr, wr, sz, a, wd, bu);
      b.chk = 1'b1; b.resp_x = rx; b.rdata_x = dx;
      return b;
   endfunction

   function automatic logic [31:0] pf(input logic [31:0] a);
      return 32'h5A5A_0000 ^ a;
   endfunction

   function automatic bit is_legal(input beat_t b);
      if (b.addr >= 32'(DEPTH * 4)) return 1'b0;
      if (b.size > 3'd2) return 1'b0;
      return (b.addr % (32'd1 << b.size)) == 32'd0;
   endfunction

   function automatic logic [31:0] model_word(input int d, input logic [31:0] a);
      int w;
      w = int'(a) & ~3;
      return {mm[d][w+3], mm[d][w+2], mm[d][w+1], mm[d][w]};
   endfunction

   task automatic commit(input int d, input beat_t b);
      int n;
      int a;
      if (b.sel && b.trans[1] && b.wr && is_legal(b)) begin
         n = 1 << b.size;
         for (int i = 0; i < n; i++) begin
            a = int'(b.addr) + i;
            mm[d][a] = b.wdata[8*(a%4) +: 8];
         end
      end
   endtask

   task automatic push_exp(input int d, input beat_t b);
      logic [31:0] rd;
      if (b.sel && b.trans[1]) begin
         if (is_legal(b)) begin
            rd = b.wr ? 32'h0 : model_word(d, b.addr);
            for (int k = 0; k < ws_of(d); k++) exp_q.push_back({2'b00, rd});
            exp_q.push_back({2'b10, rd});
         end else begin
            exp_q.push_back({2'b01, 32'h0});
            exp_q.push_back({2'b11, 32'h0});
         end
      end else begin
         exp_q.push_back({2'b10, 32'h0});
      end
   endtask

   // ---------------- driver ----------------
   task automatic drive_addr(input int d, input beat_t b);
      hsel[d]   = b.sel;
      htrans[d] = b.trans;
      hwrite[d] = b.wr;
      hsize[d]  = b.size;
      hburst[d] = b.burst;
      haddr[d]  = b.addr;
   endtask

   function automatic beat_t next_beat(inout int tail);
      if (beat_q.size() != 0) return beat_q.pop_front();
      tail++;
      return mk(1'b0, 2'd0, 1'b0, 3'd0, 32'h0, 32'h0, 3'd0);
   endfunction

   // Pipelined master: runs beat_q on instance d; entered and left at a falling edge.
   task automatic run_beats(input int d);
      beat_t       ap, dp;
      bit          dp_v, rdy;
      int          tail, cyc;
      logic [33:0] e, act;
      dp_v = 1'b0; tail = 0; cyc = 0;
      dp = mk(1'b0, 2'd0, 1'b0, 3'd0, 32'h0, 32'h0, 3'd0);
      exp_q.delete();
      ap = next_beat(tail);
      drive_addr(d, ap);
      rdy = hreadyout[d];
      while (1) begin
         @(negedge clk);
         cyc++;
         if (rdy) begin
            if (dp_v) commit(d, dp);
            dp = ap; dp_v = 1'b1;
            push_exp(d, dp);
            hwdata[d] = dp.wdata;
            ap = next_beat(tail);
            drive_addr(d, ap);
         end
         act = {hreadyout[d], hresp[d], hrdata[d]};
         if (exp_q.size() == 0) begin
            check($sformatf("data_phase_len_d%0d", d), 64'(act), 64'h3_FFFF_FFFF);
            break;
         end
         e = exp_q.pop_front();
         check($sformatf("resp_d%0d_a%h", d, dp.addr), 64'(act), 64'(e));
         if (e[33] && dp.chk) begin
            check($sformatf("tbl_hresp_d%0d_a%h", d, dp.addr), 64'(hresp[d]), 64'(dp.resp_x));
            check($sformatf("tbl_hrdata_d%0d_a%h", d, dp.addr), 64'(hrdata[d]), 64'(dp.rdata_x));
         end
         rdy = hreadyout[d];
         if (tail >= 3 && exp_q.size() == 0) break;
         if (cyc > 5000) begin
            check($sformatf("run_timeout_d%0d", d), 64'(cyc), 64'd0);
            break;
         end
      end
   endtask

   function automatic beat_t rand_beat();
      beat_t b;
      int    r;
      b = mk(1'b1, 2'd2, 1'b0, 3'd2, 32'h0, 32'h0, 3'd0);
      b.sel   = ($urandom_range(0, 9) != 0);
      b.trans = 2'($urandom_range(0, 3));
      b.wr    = 1'($urandom_range(0, 1));
      b.size  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      b.burst = 3'($urandom_range(0, 7));
      b.wdata = $urandom;
      r = $urandom_range(0, 19);
      if (r == 0)      b.addr = 32'(DEPTH * 4) + 32'($urandom_range(0, 7));
      else if (r == 1) b.addr = 32'hFFFF_FFFC;
      else if (r == 2) b.addr = 32'(DEPTH * 4 - 4) + 32'($urandom_range(0, 3));
      else             b.addr = 32'($urandom_range(0, 32'h9F));
      if (b.size <= 3'd2 && $urandom_range(0, 3) != 0)
         b.addr = b.addr & ~((32'd1 << b.size) - 32'd1);
      return b;
   endfunction

   task automatic add(input int dut, input beat_t b);
      vec_t v;
      v.dut = dut; v.b = b;
      vec.push_back(v);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      rst = 1'b1;
      for (int i = 0; i < NI; i++) begin
         hsel[i] = 1'b0; haddr[i] = 32'h0; htrans[i] = 2'd0; hwrite[i] = 1'b0;
         hsize[i] = 3'd0; hburst[i] = 3'd0; hwdata[i] = 32'h0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < NI; i++)
         check($sformatf("reset_state_d%0d", i), 64'({hreadyout[i], hresp[i], hrdata[i]}),
               64'({2'b10, 32'h0}));
      rst = 1'b0;

      // Known contents for every address the tests and random traffic touch
      for (int d = 0; d < NI; d++) begin
         for (int a = 0; a <= 32'h9C; a += 4)
            beat_q.push_back(mk(1'b1, 2'd2, 1'b1, 3'd2, 32'(a), pf(32'(a)), 3'd0));
         beat_q.push_back(mk(1'b1, 2'd2, 1'b1, 3'd2, 32'(DEPTH*4-4), pf(32'(DEPTH*4-4)), 3'd0));
         run_beats(d);
      end

      // Directed vectors: dut 0 = 0 wait states, 1 = 2, 2 = 3
      add(0, mk (1, 2'd2, 1, 3'd2, 32'h10, 32'hDEAD_BEEF, 3'd0));
      add(0, mkc(1, 2'd2, 0, 3'd2, 32'h10, 32'h0, 3'd0, 1'b0, 32'hDEAD_BEEF));
      add(2, mkc(1, 2'd2, 0, 3'd2, 32'h00, 32'h0, 3'd0, 1'b0, 32'h5A5A_0000));
      add(2, mk (1, 2'd2, 1, 3'd0, 32'h20, 32'h0000_0011, 3'd0));
      add(2, mk (1, 2'd2, 1, 3'd0, 32'h21, 32'h0000_2200, 3'd0));
      add(2, mk (1, 2'd2, 1, 3'd0, 32'h22, 32'h0033_0000, 3'd0));
      add(2, mk (1, 2'd2, 1, 3'd0, 32'h23, 32'h4400_0000, 3'd0));
      add(2, mkc(1, 2'd2, 0, 3'd2, 32'h20, 32'h0, 3'd0, 1'b0, 32'h4433_2211));
      add(2, mk (1, 2'd2, 1, 3'd1, 32'h22, 32'hABCD_0000, 3'd0));
      add(2, mkc(1, 2'd2, 0, 3'd2, 32'h20, 32'h0, 3'd0, 1'b0, 32'hABCD_2211));
      add(2, mk (1, 2'd2, 1, 3'd2, 32'h04, 32'h1234_5678, 3'd0));
      add(2, mkc(1, 2'd2, 0, 3'd2, 32'(DEPTH*4), 32'h0, 3'd0, 1'b1, 32'h0));
      add(2, mkc(1, 2'd2, 1, 3'd2, 32'h06, 32'hFFFF_FFFF, 3'd0, 1'b1, 32'h0));
      add(2, mkc(1, 2'd2, 0, 3'd2, 32'h04, 32'h0, 3'd0, 1'b0, 32'h1234_5678));
      add(2, mkc(1, 2'd2, 0, 3'd3, 32'h08, 32'h0, 3'd0, 1'b1, 32'h0));
      add(2, mkc(1, 2'd2, 0, 3'd1, 32'h09, 32'h0, 3'd0, 1'b1, 32'h0));
      add(2, mkc(1, 2'd2, 0, 3'd2, 32'(DEPTH*4-4), 32'h0, 3'd0, 1'b0, pf(32'(DEPTH*4-4))));
      add(1, mk (1, 2'd2, 1, 3'd2, 32'h40, 32'd1, 3'd3));
      add(1, mk (1, 2'd3, 1, 3'd2, 32'h44, 32'd2, 3'd3));
      add(1, mkc(1, 2'd1, 1, 3'd2, 32'h48, 32'hFFFF_FFFF, 3'd3, 1'b0, 32'h0));
      add(1, mk (1, 2'd3, 1, 3'd2, 32'h48, 32'd3, 3'd3));
      add(1, mk (1, 2'd3, 1, 3'd2, 32'h4C, 32'd4, 3'd3));
      add(1, mk (0, 2'd2, 1, 3'd2, 32'h40, 32'hFFFF_FFFF, 3'd0));
      add(1, mkc(1, 2'd2, 0, 3'd2, 32'h40, 32'h0, 3'd0, 1'b0, 32'd1));
      add(1, mkc(1, 2'd2, 0, 3'd2, 32'h44, 32'h0, 3'd0, 1'b0, 32'd2));
      add(1, mkc(1, 2'd2, 0, 3'd2, 32'h48, 32'h0, 3'd0, 1'b0, 32'd3));
      add(1, mkc(1, 2'd2, 0, 3'd2, 32'h4C, 32'h0, 3'd0, 1'b0, 32'd4));

      for (int i = 0; i < vec.size(); i++) begin
         beat_q.push_back(vec[i].b);
         if (i == vec.size() - 1 || vec[i+1].dut != vec[i].dut) run_beats(vec[i].dut);
      end

      // Reset in the second wait cycle of a write on the 3-wait-state instance
      drive_addr(2, mk(1, 2'd2, 1, 3'd2, 32'h80, 32'h0, 3'd0));
      @(negedge clk);
      check("rst_mid_wait1", 64'(hreadyout[2]), 64'd0);
      drive_addr(2, mk(0, 2'd0, 0, 3'd0, 32'h0, 32'h0, 3'd0));
      hwdata[2] = 32'h1111_1111;
      @(negedge clk);
      check("rst_mid_wait2", 64'(hreadyout[2]), 64'd0);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_after", 64'({hreadyout[2], hresp[2], hrdata[2]}), 64'({2'b10, 32'h0}));
      rst = 1'b0;
      beat_q.push_back(mkc(1, 2'd2, 0, 3'd2, 32'h80, 32'h0, 3'd0, 1'b0, 32'h5A5A_0080));
      run_beats(2);

      // Randomized traffic against the model
      for (int d = 0; d < NI; d++) begin
         repeat (200) beat_q.push_back(rand_beat());
         run_beats(d);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks so far %0d", n_checks);
      $fatal(1, "watchdog");
   end

endmodule
